// File: rtl/uart_pkg.sv
// Shared UART TX definitions: FSM states, line levels, default payload width, frame lengths.
// ST_PAR exists only when UART_TX_PARITY_EN is defined.
package uart_pkg;

  localparam int UART_DEFAULT_DATA_W = 8;

  localparam logic UART_IDLE_LEVEL  = 1'b1;
  localparam logic UART_START_LEVEL = 1'b0;

  // Frame length in baud periods: start + data + [parity] + stop.
  localparam int UART_FRAME_LEN_NOPAR = UART_DEFAULT_DATA_W + 2;
  localparam int UART_FRAME_LEN_PAR   = UART_DEFAULT_DATA_W + 3;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_DATA  = 3'd2,
`ifdef UART_TX_PARITY_EN
    ST_PAR   = 3'd3,
`endif
    ST_STOP  = 3'd4
  } uart_state_t;

  function automatic int uart_frame_len(input int data_w, input bit parity);
    return data_w + (parity ? 3 : 2);
  endfunction

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// Requester/baud side of the shared UART transmitter: master drives requests and baud tick,
// slave (the arbiter) returns the one-hot accept strobe and the registered line state.
interface uart_tx_arbiter_if import uart_pkg::*; #(
  parameter int N_REQ  = 4,
  parameter int DATA_W = UART_DEFAULT_DATA_W
) ();

  localparam int ID_W = $clog2(N_REQ);

  logic                     baud_en;
  logic [N_REQ-1:0]         req_valid;
  logic [N_REQ*DATA_W-1:0]  req_data;
  logic [N_REQ-1:0]         req_ready;
  logic                     tx;
  logic                     busy;
  logic [ID_W-1:0]          grant_id;

  modport master (
    output baud_en, req_valid, req_data,
    input  req_ready, tx, busy, grant_id
  );

  modport slave (
    input  baud_en, req_valid, req_data,
    output req_ready, tx, busy, grant_id
  );

endinterface

// File: rtl/uart_tx_arbiter_rr_arbiter.sv
// Combinational round-robin arbiter: search starts at last+1 and wraps; zero latency,
// no backpressure of its own (the caller decides when the grant is used).
module rr_arbiter #(
  parameter int N  = 4,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] last,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] idx,
  output logic          any
);

  logic [IW-1:0] cand;

  always_comb begin
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    cand  = '0;
    for (int k = 1; k <= N; k++) begin
      cand = IW'((int'(last) + k) % N);
      if (!any && req[cand]) begin
        any         = 1'b1;
        grant[cand] = 1'b1;
        idx         = cand;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter + serializer sharing one UART line; tx falls one clk after an accept.
// req_ready is a one-hot strobe only on baud_en cycles in IDLE/STOP; UART_TX_PARITY_EN adds even parity.
module uart_tx_arbiter import uart_pkg::*; #(
  parameter int N_REQ  = 4,
  parameter int DATA_W = UART_DEFAULT_DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  uart_tx_arbiter_if.slave  bus
);

  localparam int ID_W  = $clog2(N_REQ);
  localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  uart_state_t        state;
  logic [DATA_W-1:0]  shreg;
  logic [CNT_W-1:0]   bit_idx;
  logic [ID_W-1:0]    last;

  logic [N_REQ-1:0]   arb_grant;
  logic [ID_W-1:0]    arb_idx;
  logic               arb_any;
  logic               accept_pt;
  logic [DATA_W-1:0]  win_data;

`ifdef UART_TX_PARITY_EN
  logic               par_bit;
`endif

  rr_arbiter #(
    .N  (N_REQ),
    .IW (ID_W)
  ) u_arb (
    .req   (bus.req_valid),
    .last  (last),
    .grant (arb_grant),
    .idx   (arb_idx),
    .any   (arb_any)
  );

  // A reset in the same cycle wins, so no byte is handed over that would then be lost.
  assign accept_pt     = bus.baud_en && !rst && (state == ST_IDLE || state == ST_STOP);
  assign bus.req_ready = (accept_pt && arb_any) ? arb_grant : '0;
  assign win_data      = bus.req_data[arb_idx*DATA_W +: DATA_W];

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= ST_IDLE;
      shreg        <= '0;
      bit_idx      <= '0;
      last         <= ID_W'(N_REQ - 1);
      bus.tx       <= UART_IDLE_LEVEL;
      bus.busy     <= 1'b0;
      bus.grant_id <= '0;
`ifdef UART_TX_PARITY_EN
      par_bit      <= 1'b0;
`endif
    end else if (bus.baud_en) begin
      case (state)
        ST_IDLE, ST_STOP: begin
          if (arb_any) begin
            shreg        <= win_data;
            last         <= arb_idx;
            bus.grant_id <= arb_idx;
            bus.tx       <= UART_START_LEVEL;
            bus.busy     <= 1'b1;
            state        <= ST_START;
`ifdef UART_TX_PARITY_EN
            par_bit      <= ^win_data;
`endif
          end else begin
            bus.tx   <= UART_IDLE_LEVEL;
            bus.busy <= 1'b0;
            state    <= ST_IDLE;
          end
        end

        ST_START: begin
          bus.tx  <= shreg[0];
          shreg   <= shreg >> 1;
          bit_idx <= '0;
          state   <= ST_DATA;
        end

        // shreg[0] always holds the next bit to drive; bit_idx counts bits already on the line.
        ST_DATA: begin
          if (bit_idx < CNT_W'(DATA_W - 1)) begin
            bit_idx <= bit_idx + 1'b1;
            bus.tx  <= shreg[0];
            shreg   <= shreg >> 1;
          end else begin
`ifdef UART_TX_PARITY_EN
            bus.tx <= par_bit;
            state  <= ST_PAR;
`else
            bus.tx <= UART_IDLE_LEVEL;
            state  <= ST_STOP;
`endif
          end
        end

`ifdef UART_TX_PARITY_EN
        ST_PAR: begin
          bus.tx <= UART_IDLE_LEVEL;
          state  <= ST_STOP;
        end
`endif

        default: begin
          bus.tx   <= UART_IDLE_LEVEL;
          bus.busy <= 1'b0;
          state    <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Shares one 8N1 UART transmit line between `N_REQ` byte requesters. Selects requesters round-robin, serializes the granted byte LSB-first, and paces every bit with the one-cycle `baud_en` tick from the baud generator. It sits between the baud generator and the pad-level `tx` output, and replaces per-source transmitters.

## Interface
- `N_REQ`, 4: number of requesters, 2..8.
- `DATA_W`, 8: bits per frame payload.
- `clk`  in  1: system clock.
- `rst`  in  1: synchronous, active-high reset.
- `baud_en`  in  1: one-`clk` pulse per bit period, from the baud generator.
- `req_valid`  in  `N_REQ`: requester i has a byte pending.
- `req_data`  in  `N_REQ*DATA_W`: requester i's byte at `[i*DATA_W +: DATA_W]`.
- `req_ready`  out  `N_REQ`: one-hot accept strobe; a transfer occurs when `req_valid[i] & req_ready[i]`.
- `tx`  out  1: serial line, idle high.
- `busy`  out  1: a frame is in progress.
- `grant_id`  out  `$clog2(N_REQ)`: index of the requester whose frame is on `tx`.

## Operation
- **States:** `IDLE`, `START`, `DATA`, `PAR` (only with the macro), `STOP`.
- **Accept point:** a `baud_en` cycle while the state is `IDLE` or `STOP` with any `req_valid` set. All frame transitions happen only on `baud_en` cycles, so every bit lasts exactly one baud period. No partial start bit is possible.
- **At an accept point:**
  - Pick the winner with round-robin priority starting at `last+1` mod `N_REQ`.
  - Assert `req_ready[winner]` combinationally in the same cycle.
  - Register the winner's data in the shift register and set `grant_id` and `last` to the winner.
  - Set `tx` to 0 and move to `START`.
- **Requester rule:** `req_valid` and data must stay stable until `req_ready`. Dropping `req_valid` before acceptance cancels the request, and nothing is sent.
- **`START`:** on `baud_en`, `tx` takes `data[0]`, bit index is set to 0, and the state moves to `DATA`.
- **`DATA`:** on `baud_en`:
  - If index < `DATA_W-1`: index increments and `tx` takes the next bit.
  - Otherwise: move to `PAR` (`tx` takes the parity bit) or to `STOP` (`tx` goes to 1).
- **`PAR`:** on `baud_en`, `tx` goes to 1 and the state moves to `STOP`.
- **`STOP`:** on `baud_en`, either accept a new request (gapless back-to-back frames) or go to `IDLE` with `tx` held at 1.
- **`busy`:** equals `state != IDLE`.
- **Non-accept cycles:** `req_ready` is all zero whenever the cycle is not an accept point.
- **Stalled baud:** if `baud_en` stays low, the state and `tx` hold indefinitely.

## Timing
- **Reset values:**
  - `tx` = 1, `busy` = 0, `req_ready` = 0, `grant_id` = 0.
  - State `IDLE`, bit index 0, `last` = `N_REQ-1` (requester 0 has first priority).
- **Reset mid-frame:** the frame is aborted, `tx` is 1 from the next edge, and the captured byte is dropped without retry.
- **Latency:** `tx` falls on the edge after the accept point.
- **Frame length:** `DATA_W+2` baud periods, or `DATA_W+3` with parity.
- **Back-to-back frames:** consecutive accepted frames have no idle bit between the stop bit and the next start bit.
- **`req_ready` path:** purely combinational from `baud_en`, state and `req_valid`. Requesters must not feed `req_ready` combinationally back into `req_valid`.
- **Registered outputs:** `tx`, `busy` and `grant_id` are all registered, so `tx` is glitch-free.
- **Simultaneous events:** a `rst` and `baud_en` in the same cycle resolve to reset.

## Configuration
- **`UART_TX_PARITY_EN` defined:**
  - Even parity bit (XOR of the data bits) is inserted between the last data bit and stop.
  - `PAR` state exists; frame length is `DATA_W+3` periods.
- **Undefined:** 8N1 only, `PAR` state absent, frame length `DATA_W+2` periods.

## Structure
- **Shared package `uart_pkg`:**
  - State enum.
  - `UART_IDLE_LEVEL` = 1, `UART_START_LEVEL` = 0.
  - Default `DATA_W`.
  - Frame-length constants for both parity modes.
- **Sub-module `rr_arbiter`:** a combinational round-robin arbiter with inputs req vector and `last` pointer, and outputs one-hot grant plus encoded index.
- **Top level:** the FSM, shift register, bit counter and pointer register stay in the top module.

## Test plan
- **Single byte:** `req_valid[1]` with data 0xA5 → one `req_ready[1]` pulse on a `baud_en` cycle; `tx` shows 0,1,0,1,0,0,1,0,1,1 across 10 successive baud periods; `grant_id` = 1; `busy` is high for exactly 10 periods.
- **Full contention:** all four requesters valid continuously → grants in order 0,1,2,3,0; 40 consecutive bit periods carry no idle-high bit between frames.
- **Fairness:** requester 2 granted, then requesters 1 and 3 both valid → 3 is granted before 1.
- **Reset mid-frame:** `rst` during `DATA` bit 4 → `tx` = 1, `busy` = 0 and `req_ready` = 0 next cycle; the next grant goes to requester 0.
- **Parity:** with `UART_TX_PARITY_EN`, byte 0x07 → parity bit 1 and an 11-period frame; byte 0x03 → parity bit 0.
- **Cancelled request and stalled baud:** `req_valid` raised and dropped between two `baud_en` pulses → no `req_ready` and `tx` stays 1. With `baud_en` held low mid-frame, `tx` holds its value for 100 cycles.
